// File: rtl/idli_pkg.sv
// Shared types for the idli core: slice/counter types and the UART receiver state set.
package idli_pkg;

  typedef logic [3:0] slice_t;
  typedef logic [1:0] ctr_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    URX_IDLE,
    URX_START,
    URX_DATA,
    URX_STOP,
    URX_BREAK
  } urx_state_t;

  // Slice N of a byte zero-extended to a 16-bit word.
  function automatic slice_t urx_slice(input byte_t b, input ctr_t c);
    slice_t s;
    s = '0;
    case (c)
      2'd0:    s = b[3:0];
      2'd1:    s = b[7:4];
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/idli_urx_fifo_m.sv
// DEPTH-entry byte FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module idli_urx_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  empty_nxt,
  output logic  drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count, count_nxt;
  logic           full, empty, push_ok, pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign drop      = push & full & ~pop_ok;
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign empty_nxt = (count_nxt == '0);
  assign head      = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/idli_urx_m.sv
// UART 8N1 receiver: deserialises bytes into a FIFO and presents them to ex as 4-slice words.
module idli_urx_m
  import idli_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 2
) (
  input  logic       i_urx_gck,
  input  logic       i_urx_rst_n,
  input  ctr_t       i_urx_ctr,
  input  logic       i_urx_data,
  output slice_t     o_urx_data,
  output logic       o_urx_vld,
  input  logic       i_urx_acp,
  output logic       o_urx_ovf,
  output logic       o_urx_ferr,
  input  logic       i_urx_clr,
  output urx_state_t o_urx_state
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);

  logic          rx_m, rx_s;
  urx_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  byte_t         shreg_q, shreg_d;
  logic          push_q, push_d, ferr_set;
  logic          vld_q, pop, empty_nxt, drop;
  byte_t         head;

  always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
    if (!i_urx_rst_n) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state_q  <= URX_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      push_q   <= 1'b0;
    end else begin
      rx_m     <= i_urx_data;
      rx_s     <= rx_m;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      push_q   <= push_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      URX_IDLE: begin
        if (!rx_s) begin
          state_d = URX_START;
          timer_d = '0;
        end
      end
      URX_START: begin
        if (timer_q == HALF_T) begin
          if (rx_s) begin
            state_d = URX_IDLE;
          end else begin
            state_d  = URX_DATA;
            timer_d  = '0;
            bitcnt_d = '0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      URX_DATA: begin
        if (timer_q == LAST_T) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          timer_d = '0;
          if (bitcnt_q == 3'd7) state_d = URX_STOP;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      URX_STOP: begin
        if (timer_q == LAST_T) begin
          timer_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = URX_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = URX_BREAK;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      URX_BREAK: begin
        // Stay here until the line returns high so a held-low line yields no frames.
        if (rx_s) state_d = URX_IDLE;
      end
      default: state_d = URX_IDLE;
    endcase
  end

  idli_urx_fifo_m #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_urx_gck),
    .rst_n     (i_urx_rst_n),
    .push      (push_q),
    .push_data (shreg_q),
    .pop       (pop),
    .head      (head),
    .empty_nxt (empty_nxt),
    .drop      (drop)
  );

  // Handshake: a word is offered for the whole ctr 0..3 window when vld=1 and is
  // consumed at the ctr==3 edge when acp=1; otherwise it is re-offered next window.
  assign pop = vld_q & (i_urx_ctr == 2'd3) & i_urx_acp;

  always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
    if (!i_urx_rst_n) begin
      vld_q      <= 1'b0;
      o_urx_ovf  <= 1'b0;
      o_urx_ferr <= 1'b0;
    end else begin
      if (i_urx_ctr == 2'd3) vld_q <= ~empty_nxt;
      if (drop)           o_urx_ovf <= 1'b1;
      else if (i_urx_clr) o_urx_ovf <= 1'b0;
      if (ferr_set)       o_urx_ferr <= 1'b1;
      else if (i_urx_clr) o_urx_ferr <= 1'b0;
    end
  end

  assign o_urx_vld   = vld_q;
  assign o_urx_data  = vld_q ? urx_slice(head, i_urx_ctr) : '0;
  assign o_urx_state = state_q;

endmodule
